// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, zero-bit stuffing, idle fill and abort.
// One line bit per clock, all outputs registered except the gated ready.
module hdlc_tx_framer #(
  parameter int STUFF_LEN = 5,
  parameter int MIN_IDLE  = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Valid,
  input  logic       Tx_Last,
  output logic       Tx_Ready,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_ActiveFrame,
  output logic       Tx_Done,
  output logic       Tx_Aborted,
  output logic       Tx_Underrun
);
  localparam int SW = $clog2(STUFF_LEN + 1);
  localparam int IW = $clog2(MIN_IDLE + 1);
  localparam logic [SW-1:0] STUFF_MAX = SW'(STUFF_LEN);
  localparam logic [IW-1:0] IDLE_MAX = IW'(MIN_IDLE);

  typedef enum logic [2:0] {
    IDLE, START_FLAG, DATA, END_FLAG, ABORT
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [SW-1:0] stuff_cnt;
  logic [IW-1:0] idle_cnt;
  logic [7:0]    byte_q;
  logic          last_q;
  logic          tail;
  logic          rdy_q;
  logic [1:0]    fin;

  logic          abort_req;
  logic          in_frame;
  logic          kill;
  logic          flag_bit;
  logic          dbit;
  logic [SW-1:0] dcnt;

  assign abort_req = Tx_AbortFrame | ~Tx_Enable;
  assign in_frame  = (state == START_FLAG) || (state == DATA) ||
                     (state == END_FLAG);
  assign kill      = in_frame && (abort_req || (rdy_q && !Tx_Valid));
  assign flag_bit  = (idx != 3'd0) && (idx != 3'd7);
  assign Tx_Ready  = rdy_q & ~abort_req;

  // a ready cycle emits bit 0 of the incoming byte straight away
  always_comb begin
    dbit = rdy_q ? Tx_Data[0] : byte_q[idx];
    dcnt = dbit ? stuff_cnt + 1'b1 : '0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state          <= IDLE;
      idx            <= '0;
      stuff_cnt      <= '0;
      idle_cnt       <= IDLE_MAX;
      byte_q         <= '0;
      last_q         <= 1'b0;
      tail           <= 1'b0;
      rdy_q          <= 1'b0;
      fin            <= '0;
      Tx             <= 1'b1;
      Tx_ActiveFrame <= 1'b0;
      Tx_Done        <= 1'b0;
      Tx_Aborted     <= 1'b0;
      Tx_Underrun    <= 1'b0;
    end else begin
      Tx_Done     <= 1'b0;
      Tx_Aborted  <= 1'b0;
      Tx_Underrun <= 1'b0;
      if (kill) begin
        Tx_Underrun <= rdy_q && !Tx_Valid;
        Tx          <= 1'b0;
        state       <= ABORT;
        idx         <= 3'd1;
        rdy_q       <= 1'b0;
        tail        <= 1'b0;
        stuff_cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            Tx             <= 1'b1;
            Tx_Done        <= fin[0];
            Tx_Aborted     <= fin[1];
            fin            <= '0;
            Tx_ActiveFrame <= 1'b0;
            if (idle_cnt != IDLE_MAX)
              idle_cnt <= idle_cnt + 1'b1;
            if (Tx_Enable && Tx_Valid && idle_cnt == IDLE_MAX) begin
              Tx             <= 1'b0;
              Tx_ActiveFrame <= 1'b1;
              state          <= START_FLAG;
              idx            <= 3'd1;
              stuff_cnt      <= '0;
            end
          end
          START_FLAG, END_FLAG: begin
            Tx        <= flag_bit;
            idx       <= idx + 3'd1;
            stuff_cnt <= '0;
            if (idx == 3'd7) begin
              if (state == START_FLAG) begin
                state <= DATA;
                rdy_q <= 1'b1;
              end else begin
                state    <= IDLE;
                idle_cnt <= '0;
                fin      <= 2'b01;
              end
            end
          end
          DATA: begin
            if (rdy_q) begin
              rdy_q     <= 1'b0;
              byte_q    <= Tx_Data;
              last_q    <= Tx_Last;
              Tx        <= dbit;
              stuff_cnt <= dcnt;
              idx       <= 3'd1;
            end else if (stuff_cnt == STUFF_MAX) begin
              Tx        <= 1'b0;
              stuff_cnt <= '0;
              if (tail) begin
                tail <= 1'b0;
                if (last_q) begin
                  state <= END_FLAG;
                  idx   <= '0;
                end else begin
                  rdy_q <= 1'b1;
                end
              end
            end else begin
              Tx        <= dbit;
              stuff_cnt <= dcnt;
              idx       <= idx + 3'd1;
              if (idx == 3'd7) begin
                if (dcnt == STUFF_MAX) begin
                  tail <= 1'b1;
                end else if (last_q) begin
                  state <= END_FLAG;
                  idx   <= '0;
                end else begin
                  rdy_q <= 1'b1;
                end
              end
            end
          end
          ABORT: begin
            Tx  <= 1'b1;
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              state    <= IDLE;
              idle_cnt <= '0;
              fin      <= 2'b10;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
